blockmem_banked: RTL and testbench
==================================

Name: blockmem_banked

Overview:
- Parametrised successor scratchpad for the systolic mesh.
- NRD tile-read channels and NWR tile-write channels from the array, with a registered 1-cycle read.
- A handshaked burst loader that streams one block of LOADWIDTH*LOADBEATS words.
- A sequential clear engine that replaces per-word reset of storage; sits between the host loader and the mesh.

Parameters:
ADDRSIZE, 256, memory depth in words (power of 2, multiple of LOADWIDTH*LOADBEATS)
BITWIDTH, 8, word width, signed
TILEUNITS, 4, words per tile access (power of 2)
NRD, 3, tile-read channels
NWR, 2, tile-write channels
LOADWIDTH, 4, words per loader beat (power of 2)
LOADBEATS, 16, beats per loader block (power of 2)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
rd_valid  in  NRD  read request per channel
rd_addr  in  NRD*AW  word address per channel, AW=$clog2(ADDRSIZE)
rd_data  out  NRD*TILEUNITS*BITWIDTH  tile data, word 0 at LSBs
rd_data_valid  out  NRD  rd_data qualifier
wr_valid  in  NWR  tile write request per channel
wr_addr  in  NWR*AW  word address per channel
wr_data  in  NWR*TILEUNITS*BITWIDTH  tile data
loader_start  in  1  begin block load
loader_base  in  AW  block base address
loader_valid  in  1  beat valid
loader_ready  out  1  beat accepted when valid&ready
loader_data  in  LOADWIDTH*BITWIDTH  beat data
loader_done  out  1  1-cycle pulse after last beat
clear_start  in  1  begin zero sweep
clear_done  out  1  1-cycle pulse after sweep
busy  out  1  loader or clear engine not idle

Behaviour:
- Reset (reset=0, async): all outputs 0, both FSMs idle, counters 0, read pipeline cleared. Storage contents are NOT reset; undefined until written or cleared.
- Address alignment:
  - Tile addresses: low $clog2(TILEUNITS) bits forced to 0.
  - Loader base: low $clog2(LOADWIDTH*LOADBEATS) bits forced to 0.
  - All address arithmetic wraps modulo ADDRSIZE.
- Reads:
  - rd_valid[i] at edge N -> rd_data[i] and rd_data_valid[i]=1 after edge N+1.
  - rd_data holds its value when not valid.
  - Reads are ignored (rd_data_valid=0) while the clear FSM is in CLEAR.
  - Read and write to the same word in one cycle: the read returns old data.
- Array writes:
  - Always accepted; no ready signal. Take effect at the clock edge.
  - Same tile from two channels in one cycle: the higher channel index wins.
  - Writes during CLEAR are performed; the clear pointer stalls that cycle.
- Loader FSM, states L_IDLE, L_RUN, L_DONE:
  - L_IDLE: loader_start=1 and clear FSM idle -> latch aligned base, beat=0, go to L_RUN. loader_start in any other state is ignored.
  - L_RUN: loader_ready = ~|wr_valid (array writes have priority).
    - On valid&ready: write LOADWIDTH words at base+beat*LOADWIDTH, then beat++.
    - Beat LOADBEATS-1 accepted -> L_DONE.
  - L_DONE: loader_done=1 for one cycle -> L_IDLE.
  - loader_ready=0 in L_IDLE and L_DONE.
- Clear FSM, states C_IDLE, CLEAR, C_DONE:
  - C_IDLE: clear_start=1 and loader FSM in L_IDLE -> ptr=0, go to CLEAR. If loader_start and clear_start are both asserted in idle, loader_start wins and clear_start is dropped.
  - CLEAR: each cycle with no wr_valid, zero TILEUNITS words at ptr, then ptr += TILEUNITS.
    - Last tile (ptr=ADDRSIZE-TILEUNITS) written -> C_DONE.
    - Nominal duration: ADDRSIZE/TILEUNITS cycles.
  - C_DONE: clear_done=1 for one cycle -> C_IDLE.
- busy = (loader FSM != L_IDLE) | (clear FSM != C_IDLE).
- Reset asserted mid-load or mid-clear: operation aborts, no done pulse, partial writes remain.

Test Plan:
- Reset then full clear: clear_start -> clear_done exactly 64 cycles later (defaults). Reads of addrs 0, 4, 252 then return all-zero tiles with rd_data_valid one cycle after rd_valid.
- Loader burst: start at base 0x47 -> aligned base 0x40. 16 beats carrying word values 1..64 -> words 0x40..0x7F = 1..64, loader_done pulses once, busy drops the cycle after.
- Backpressure: wr_valid[0]=1 on beats 3 and 7 -> loader_ready=0 those cycles, beat count unaffected, final memory identical to the no-contention case.
- Write collision: channels 0 and 1 both write tile addr 8 with 0x11.. and 0x22.. -> read of addr 8 returns 0x22 in all 4 words. A same-cycle read of addr 8 returns the prior contents.
- Wrap and alignment: write tile at addr 0x103 (ADDRSIZE=256) -> lands at 0x00; rd_addr 0x01 returns it.
- Reset mid-load after beat 5 -> no loader_done, busy=0 immediately, words 0x40..0x57 hold the loaded data.

Source files
------------

// File: rtl/blockmem_banked.sv
//==============================================================================
// Module   : blockmem_banked
// Purpose  : Banked scratchpad for the systolic mesh. Multi-channel tile
//            reads (registered, 1-cycle latency) and tile writes from the
//            array, a handshaked burst loader that fills one aligned block,
//            and a sequential clear engine that zeroes the whole store.
// Ports    : clock, reset (async, active-low)
//            rd_valid/rd_addr -> rd_data/rd_data_valid   (NRD channels)
//            wr_valid/wr_addr/wr_data                   (NWR channels)
//            loader_start/base/valid/data -> loader_ready/loader_done
//            clear_start -> clear_done
//            busy : loader or clear engine active
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module blockmem_banked #(
    parameter int ADDRSIZE  = 256,
    parameter int BITWIDTH  = 8,
    parameter int TILEUNITS = 4,
    parameter int NRD       = 3,
    parameter int NWR       = 2,
    parameter int LOADWIDTH = 4,
    parameter int LOADBEATS = 16
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NRD-1:0]                          rd_valid,
    input  logic [NRD*$clog2(ADDRSIZE)-1:0]         rd_addr,
    output logic [NRD*TILEUNITS*BITWIDTH-1:0]       rd_data,
    output logic [NRD-1:0]                          rd_data_valid,
    input  logic [NWR-1:0]                          wr_valid,
    input  logic [NWR*$clog2(ADDRSIZE)-1:0]         wr_addr,
    input  logic [NWR*TILEUNITS*BITWIDTH-1:0]       wr_data,
    input  logic                                    loader_start,
    input  logic [$clog2(ADDRSIZE)-1:0]             loader_base,
    input  logic                                    loader_valid,
    output logic                                    loader_ready,
    input  logic [LOADWIDTH*BITWIDTH-1:0]           loader_data,
    output logic                                    loader_done,
    input  logic                                    clear_start,
    output logic                                    clear_done,
    output logic                                    busy
);

    localparam int AW    = $clog2(ADDRSIZE);
    localparam int BLK   = LOADWIDTH * LOADBEATS;
    localparam int BEATW = (LOADBEATS > 1) ? $clog2(LOADBEATS) : 1;

    localparam logic [AW-1:0]    TILE_MASK = ~AW'(TILEUNITS - 1);
    localparam logic [AW-1:0]    BLK_MASK  = ~AW'(BLK - 1);
    localparam logic [AW-1:0]    LAST_TILE = AW'(ADDRSIZE - TILEUNITS);
    localparam logic [AW-1:0]    TILE_STEP = AW'(TILEUNITS);
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(LOADBEATS - 1);

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_RUN  = 2'd1,
        L_DONE = 2'd2
    } ld_state_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        CLEAR  = 2'd1,
        C_DONE = 2'd2
    } cl_state_e;

    // Storage: intentionally without reset, the clear engine replaces it.
    logic [BITWIDTH-1:0] mem_q [ADDRSIZE];

    ld_state_e           ld_state_q, ld_state_d;
    logic [AW-1:0]       ld_base_q,  ld_base_d;
    logic [BEATW-1:0]    ld_beat_q,  ld_beat_d;
    cl_state_e           cl_state_q, cl_state_d;
    logic [AW-1:0]       cl_ptr_q,   cl_ptr_d;

    logic [NRD*TILEUNITS*BITWIDTH-1:0] rd_data_q;
    logic [NRD-1:0]                    rd_vld_q;

    logic          any_wr;
    logic          ld_we;
    logic          cl_we;
    logic          rd_en;
    logic [AW-1:0] ld_waddr;
    logic [AW-1:0] rd_tile [NRD];
    logic [AW-1:0] wr_tile [NWR];

    assign any_wr   = |wr_valid;
    assign rd_en    = (cl_state_q != CLEAR);
    assign ld_waddr = ld_base_q + AW'(int'(ld_beat_q) * LOADWIDTH);

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_tile[i] = rd_addr[i*AW +: AW] & TILE_MASK;
        end
        for (int j = 0; j < NWR; j++) begin
            wr_tile[j] = wr_addr[j*AW +: AW] & TILE_MASK;
        end
    end

    //--------------------------------------------------------------------------
    // Loader FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_state_q <= L_IDLE;
            ld_base_q  <= '0;
            ld_beat_q  <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            ld_base_q  <= ld_base_d;
            ld_beat_q  <= ld_beat_d;
        end
    end

    always_comb begin
        ld_state_d   = ld_state_q;
        ld_base_d    = ld_base_q;
        ld_beat_d    = ld_beat_q;
        loader_ready = 1'b0;
        loader_done  = 1'b0;
        ld_we        = 1'b0;
        case (ld_state_q)
            L_IDLE: begin
                if (loader_start && (cl_state_q == C_IDLE)) begin
                    ld_base_d  = loader_base & BLK_MASK;
                    ld_beat_d  = '0;
                    ld_state_d = L_RUN;
                end
            end
            L_RUN: begin
                // Array writes own the write port; the loader yields to them.
                loader_ready = ~any_wr;
                if (loader_valid && !any_wr) begin
                    ld_we     = 1'b1;
                    ld_beat_d = ld_beat_q + BEATW'(1);
                    if (ld_beat_q == LAST_BEAT) begin
                        ld_state_d = L_DONE;
                    end
                end
            end
            L_DONE: begin
                loader_done = 1'b1;
                ld_state_d  = L_IDLE;
            end
            default: ld_state_d = L_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Clear FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cl_state_q <= C_IDLE;
            cl_ptr_q   <= '0;
        end else begin
            cl_state_q <= cl_state_d;
            cl_ptr_q   <= cl_ptr_d;
        end
    end

    always_comb begin
        cl_state_d = cl_state_q;
        cl_ptr_d   = cl_ptr_q;
        clear_done = 1'b0;
        cl_we      = 1'b0;
        case (cl_state_q)
            C_IDLE: begin
                // A simultaneous loader_start takes precedence.
                if (clear_start && (ld_state_q == L_IDLE) && !loader_start) begin
                    cl_ptr_d   = '0;
                    cl_state_d = CLEAR;
                end
            end
            CLEAR: begin
                // Pointer stalls on any array write cycle.
                if (!any_wr) begin
                    cl_we    = 1'b1;
                    cl_ptr_d = cl_ptr_q + TILE_STEP;
                    if (cl_ptr_q == LAST_TILE) begin
                        cl_state_d = C_DONE;
                    end
                end
            end
            C_DONE: begin
                clear_done = 1'b1;
                cl_state_d = C_IDLE;
            end
            default: cl_state_d = C_IDLE;
        endcase
    end

    assign busy = (ld_state_q != L_IDLE) || (cl_state_q != C_IDLE);

    //--------------------------------------------------------------------------
    // Storage writes. Array channels are applied last and in ascending order,
    // so the highest channel wins a same-tile collision.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (cl_we) begin
            for (int k = 0; k < TILEUNITS; k++) begin
                mem_q[cl_ptr_q + AW'(k)] <= '0;
            end
        end
        if (ld_we) begin
            for (int k = 0; k < LOADWIDTH; k++) begin
                mem_q[ld_waddr + AW'(k)] <= loader_data[k*BITWIDTH +: BITWIDTH];
            end
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_valid[j]) begin
                for (int k = 0; k < TILEUNITS; k++) begin
                    mem_q[wr_tile[j] + AW'(k)] <=
                        wr_data[(j*TILEUNITS + k)*BITWIDTH +: BITWIDTH];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Registered reads; old data on same-cycle read/write.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
            rd_vld_q  <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                rd_vld_q[i] <= rd_valid[i] && rd_en;
                if (rd_valid[i] && rd_en) begin
                    for (int k = 0; k < TILEUNITS; k++) begin
                        rd_data_q[(i*TILEUNITS + k)*BITWIDTH +: BITWIDTH] <=
                            mem_q[rd_tile[i] + AW'(k)];
                    end
                end
            end
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_blockmem_banked.sv
//==============================================================================
// Module   : tb_blockmem_banked
// Purpose  : Self-checking bench for blockmem_banked. A word-level reference
//            memory plus simple phase tracking predicts every read tile,
//            loader_ready, done pulses and busy; read expectations go into a
//            scoreboard queue that a negedge monitor drains.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_blockmem_banked;

    localparam int AS  = 256;
    localparam int BW  = 8;
    localparam int TU  = 4;
    localparam int NRD = 3;
    localparam int NWR = 2;
    localparam int LW  = 4;
    localparam int LB  = 16;
    localparam int AW  = $clog2(AS);
    localparam int BLK = LW * LB;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NRD-1:0]         rd_valid = '0;
    logic [NRD*AW-1:0]      rd_addr = '0;
    logic [NRD*TU*BW-1:0]   rd_data;
    logic [NRD-1:0]         rd_data_valid;
    logic [NWR-1:0]         wr_valid = '0;
    logic [NWR*AW-1:0]      wr_addr = '0;
    logic [NWR*TU*BW-1:0]   wr_data = '0;
    logic                   loader_start = 1'b0;
    logic [AW-1:0]          loader_base = '0;
    logic                   loader_valid = 1'b0;
    logic                   loader_ready;
    logic [LW*BW-1:0]       loader_data = '0;
    logic                   loader_done;
    logic                   clear_start = 1'b0;
    logic                   clear_done;
    logic                   busy;

    blockmem_banked #(
        .ADDRSIZE(AS), .BITWIDTH(BW), .TILEUNITS(TU), .NRD(NRD), .NWR(NWR),
        .LOADWIDTH(LW), .LOADBEATS(LB)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .loader_start(loader_start), .loader_base(loader_base),
        .loader_valid(loader_valid), .loader_ready(loader_ready),
        .loader_data(loader_data), .loader_done(loader_done),
        .clear_start(clear_start), .clear_done(clear_done), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model
    logic [BW-1:0] mm [AS];
    bit            kn [AS];
    int            ld_ph = 0;   // 0 idle, 1 loading, 2 done pulse
    int            cl_ph = 0;   // 0 idle, 1 clearing, 2 done pulse
    int            m_base, m_beat, m_ptr;
    int            ld_done_cnt = 0;

    typedef struct {
        int              ch;
        int              due;
        logic [TU*BW-1:0] d;
        logic [TU*BW-1:0] m;
    } exp_t;
    exp_t sb[$];

    function automatic int algn(input int a, input int g);
        return (a / g) * g;
    endfunction

    // Scoreboard monitor
    logic [TU*BW-1:0] last [NRD];
    logic [NRD-1:0]   mon_seen;
    exp_t             me;

    always @(negedge clock) begin
        mon_seen = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            me = sb.pop_front();
            if (me.due < cyc) begin
                chk("rd_latency", 64'(cyc), 64'(me.due));
            end else begin
                mon_seen[me.ch] = 1'b1;
                chk("rd_valid", 64'(rd_data_valid[me.ch]), 64'd1);
                chk("rd_data", 64'(rd_data[me.ch*TU*BW +: TU*BW] & me.m), 64'(me.d & me.m));
            end
        end
        for (int i = 0; i < NRD; i++) begin
            if (!mon_seen[i]) begin
                chk("rd_spurious", 64'(rd_data_valid[i]), 64'd0);
                chk("rd_hold", 64'(rd_data[i*TU*BW +: TU*BW]), 64'(last[i]));
            end
            last[i] = rd_data[i*TU*BW +: TU*BW];
        end
    end

    // One clock cycle with the currently driven inputs.
    task automatic commit();
        exp_t e;
        int   a, nld, ncl;
        bit   exp_rdy;
        #1;
        exp_rdy = (ld_ph == 1) && (wr_valid == '0);
        chk("loader_ready", 64'(loader_ready), 64'(exp_rdy));
        if (cl_ph != 1) begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_valid[i]) begin
                    a = algn(int'(rd_addr[i*AW +: AW]), TU);
                    e.ch = i; e.due = cyc + 1; e.d = '0; e.m = '0;
                    for (int k = 0; k < TU; k++) begin
                        e.d[k*BW +: BW] = mm[(a + k) % AS];
                        e.m[k*BW +: BW] = kn[(a + k) % AS] ? {BW{1'b1}} : {BW{1'b0}};
                    end
                    sb.push_back(e);
                end
            end
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_valid[j]) begin
                a = algn(int'(wr_addr[j*AW +: AW]), TU);
                for (int k = 0; k < TU; k++) begin
                    mm[(a + k) % AS] = wr_data[(j*TU + k)*BW +: BW];
                    kn[(a + k) % AS] = 1'b1;
                end
            end
        end
        nld = ld_ph;
        ncl = cl_ph;
        case (ld_ph)
            0: if (loader_start && cl_ph == 0) begin
                   m_base = algn(int'(loader_base), BLK); m_beat = 0; nld = 1;
               end
            1: if (exp_rdy && loader_valid) begin
                   for (int k = 0; k < LW; k++) begin
                       a = (m_base + m_beat*LW + k) % AS;
                       mm[a] = loader_data[k*BW +: BW];
                       kn[a] = 1'b1;
                   end
                   m_beat++;
                   if (m_beat == LB) nld = 2;
               end
            default: nld = 0;
        endcase
        case (cl_ph)
            0: if (clear_start && ld_ph == 0 && !loader_start) begin
                   m_ptr = 0; ncl = 1;
               end
            1: if (wr_valid == '0) begin
                   for (int k = 0; k < TU; k++) begin
                       mm[m_ptr + k] = '0;
                       kn[m_ptr + k] = 1'b1;
                   end
                   m_ptr += TU;
                   if (m_ptr == AS) ncl = 2;
               end
            default: ncl = 0;
        endcase
        ld_ph = nld;
        cl_ph = ncl;
        @(posedge clock);
        #1;
        if (loader_done) ld_done_cnt++;
        chk("loader_done", 64'(loader_done), 64'(ld_ph == 2));
        chk("clear_done", 64'(clear_done), 64'(cl_ph == 2));
        chk("busy", 64'(busy), 64'(ld_ph != 0 || cl_ph != 0));
    endtask

    task automatic idle_inputs();
        rd_valid = '0; wr_valid = '0; loader_start = 1'b0;
        loader_valid = 1'b0; clear_start = 1'b0;
    endtask

    task automatic rd(input int ch, input int addr);
        rd_valid[ch] = 1'b1;
        rd_addr[ch*AW +: AW] = AW'(addr);
    endtask

    task automatic wr(input int ch, input int addr, input logic [TU*BW-1:0] d);
        wr_valid[ch] = 1'b1;
        wr_addr[ch*AW +: AW] = AW'(addr);
        wr_data[ch*TU*BW +: TU*BW] = d;
    endtask

    task automatic readback(input int lo, input int ntiles);
        for (int t = 0; t < ntiles; t++) begin
            rd_valid = '0;
            rd((t % NRD), lo + t*TU);
            commit();
        end
        rd_valid = '0;
        commit();
    endtask

    task automatic load_block(input int base, input int nbeats, input bit contend);
        loader_start = 1'b1;
        loader_base  = AW'(base);
        commit();
        loader_start = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < LW; k++) loader_data[k*BW +: BW] = BW'(b*LW + k + 1);
            loader_valid = 1'b1;
            if (contend && (b == 3 || b == 7)) begin
                wr(0, 'hC0, TU*BW'($urandom));
                commit();
                wr_valid = '0;
            end
            commit();
        end
        loader_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < NRD; i++) last[i] = '0;
        ld_ph = 0;
        cl_ph = 0;
    endtask

    int n;

    initial begin
        for (int i = 0; i < AS; i++) begin mm[i] = '0; kn[i] = 1'b0; end
        for (int i = 0; i < NRD; i++) last[i] = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_valid", 64'(rd_data_valid), 64'd0);
        chk("rst_ready", 64'(loader_ready), 64'd0);
        chk("rst_ld_done", 64'(loader_done), 64'd0);
        chk("rst_cl_done", 64'(clear_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        commit();

        // Full clear; a read issued mid-sweep must be ignored
        clear_start = 1'b1;
        commit();
        clear_start = 1'b0;
        n = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) rd(0, 0);
            commit();
            rd_valid = '0;
            if (clear_done) begin n = c; break; end
        end
        chk("clear_latency", 64'(n), 64'd64);
        commit();
        rd(0, 0); rd(1, 4); rd(2, 252);
        commit();
        idle_inputs();
        commit();

        // Loader burst at unaligned base, no contention
        ld_done_cnt = 0;
        load_block('h47, LB, 1'b0);
        commit();
        commit();
        chk("ld_done_count", 64'(ld_done_cnt), 64'd1);
        readback('h40, BLK / TU);

        // Same burst with array-write contention on beats 3 and 7
        ld_done_cnt = 0;
        load_block('h47, LB, 1'b1);
        commit();
        commit();
        chk("ld_done_count_bp", 64'(ld_done_cnt), 64'd1);
        readback('h40, BLK / TU);

        // Same-tile collision plus same-cycle read of old data
        wr(0, 8, {TU{8'h11}});
        wr(1, 8, {TU{8'h22}});
        rd(0, 8);
        commit();
        idle_inputs();
        rd(1, 8);
        commit();
        idle_inputs();
        commit();

        // Address wrap and alignment
        wr(0, 'h103, 32'hA1B2C3D4);
        commit();
        idle_inputs();
        rd(2, 1);
        commit();
        idle_inputs();
        commit();

        // Randomised traffic
        for (int c = 0; c < 500; c++) begin
            rd_valid     = NRD'($urandom);
            rd_addr      = (NRD*AW)'($urandom);
            wr_valid     = '0;
            for (int j = 0; j < NWR; j++) wr_valid[j] = ($urandom_range(0, 3) == 0);
            wr_addr      = (NWR*AW)'($urandom);
            wr_data      = (NWR*TU*BW)'({$urandom, $urandom});
            loader_start = ($urandom_range(0, 29) == 0);
            loader_base  = AW'($urandom);
            loader_valid = ($urandom_range(0, 9) < 7);
            loader_data  = (LW*BW)'($urandom);
            clear_start  = ($urandom_range(0, 149) == 0);
            commit();
        end
        idle_inputs();
        for (int c = 0; c < 300 && (ld_ph != 0 || cl_ph != 0); c++) begin
            loader_valid = 1'b1;
            loader_data  = (LW*BW)'($urandom);
            commit();
        end
        idle_inputs();
        commit();
        chk("rand_drained", 64'(ld_ph + cl_ph), 64'd0);

        // Reset in the middle of a load, after beat 5
        ld_done_cnt = 0;
        load_block('h40, 6, 1'b0);
        do_reset();
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ld_done", 64'(loader_done), 64'd0);
        chk("abort_ready", 64'(loader_ready), 64'd0);
        chk("abort_rd_valid", 64'(rd_data_valid), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        commit();
        commit();
        chk("abort_no_done", 64'(ld_done_cnt), 64'd0);
        readback('h40, 6);

        commit();
        commit();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
